// File: rtl/dequant_zigzag_writer_if.sv
// Coefficient stream and SRAM write bus for the dequantizing zig-zag writer.
// The block side uses the slave modport; the coefficient source/SRAM side uses master.
interface dequant_zigzag_writer_if;
    logic               Enable;
    logic               Q_select;
    logic signed [15:0] coeff_in;
    logic               coeff_valid;
    logic               coeff_ready;
    logic [17:0]        SRAM_address;
    logic signed [15:0] SRAM_write_data;
    logic               SRAM_we_n;
    logic               Done;

    modport master (
        output Enable, Q_select, coeff_in, coeff_valid,
        input  coeff_ready, SRAM_address, SRAM_write_data, SRAM_we_n, Done
    );

    modport slave (
        input  Enable, Q_select, coeff_in, coeff_valid,
        output coeff_ready, SRAM_address, SRAM_write_data, SRAM_we_n, Done
    );
endinterface

// File: rtl/dequant_zigzag_writer.sv
// Dequantizes zig-zag ordered DCT coefficients and writes them row-major into the
// pre-IDCT SRAM region, one coefficient per cycle, segments Y then U then V.
module dequant_zigzag_writer #(
    parameter int unsigned Y_BLOCK_COLS  = 40,
    parameter int unsigned Y_BLOCK_ROWS  = 30,
    parameter int unsigned UV_BLOCK_COLS = 20,
    parameter int unsigned UV_BLOCK_ROWS = 30
) (
    input  logic                  Clock,
    input  logic                  Reset,
    dequant_zigzag_writer_if.slave bus
);

    localparam logic [17:0] PRE_IDCT_BASE = 18'd76800;
    localparam logic [17:0] U_SEG_BASE    = 18'd76800;
    localparam logic [17:0] V_SEG_BASE    = 18'd115200;

    typedef enum logic [1:0] {
        S_DQ_IDLE,
        S_DQ_ACTIVE,
        S_DQ_FLUSH,
        S_DQ_DONE
    } state_t;

    state_t state, state_n;

    logic [5:0] k;
    logic [5:0] block_col;
    logic [4:0] block_row;
    logic [1:0] seg;
    logic       q_sel;

    logic               accept;
    logic               last_col, last_row, last_coeff;
    logic [5:0]         rc;
    logic [2:0]         r, c;
    logic [3:0]         d;
    logic [2:0]         shift;
    logic signed [23:0] wide;
    logic signed [15:0] data_n;
    logic [7:0]         row_idx;
    logic [8:0]         col_off;
    logic [17:0]        row_off, seg_base, addr_n;

    // Position of the k-th coefficient along the anti-diagonal walk: odd
    // diagonals run with r increasing, even ones with r decreasing.
    function automatic logic [5:0] zz_pos(input logic [5:0] kk);
        logic [5:0]  pos;
        int unsigned n, rr, cc;
        pos = '0;
        n   = 0;
        for (int unsigned dd = 0; dd < 15; dd++) begin
            for (int unsigned j = 0; j < 8; j++) begin
                rr = dd[0] ? j : 7 - j;
                if (rr <= dd && dd - rr <= 7) begin
                    cc = dd - rr;
                    if (n == 32'(kk))
                        pos = {rr[2:0], cc[2:0]};
                    n++;
                end
            end
        end
        return pos;
    endfunction

    function automatic logic [2:0] shift_of(input logic [3:0] dd, input logic q);
        logic [2:0] s;
        if (!q) begin
            case (dd)
                4'd0:        s = 3'd3;
                4'd1:        s = 3'd2;
                4'd2, 4'd3:  s = 3'd3;
                4'd4, 4'd5:  s = 3'd4;
                4'd6, 4'd7:  s = 3'd5;
                4'd8, 4'd9:  s = 3'd6;
                default:     s = 3'd7;
            endcase
        end else begin
            case (dd)
                4'd0:             s = 3'd3;
                4'd1, 4'd2, 4'd3: s = 3'd1;
                4'd4, 4'd5:       s = 3'd2;
                4'd6, 4'd7:       s = 3'd3;
                4'd8, 4'd9:       s = 3'd4;
                default:          s = 3'd5;
            endcase
        end
        return s;
    endfunction

    always_comb begin
        accept   = bus.coeff_valid && (state == S_DQ_ACTIVE);
        last_col = (seg == 2'd0) ? (block_col == 6'(Y_BLOCK_COLS - 1))
                                 : (block_col == 6'(UV_BLOCK_COLS - 1));
        last_row = (seg == 2'd0) ? (block_row == 5'(Y_BLOCK_ROWS - 1))
                                 : (block_row == 5'(UV_BLOCK_ROWS - 1));
        last_coeff = accept && (k == 6'd63) && last_col && last_row && (seg == 2'd2);

        rc    = zz_pos(k);
        r     = rc[5:3];
        c     = rc[2:0];
        d     = {1'b0, r} + {1'b0, c};
        shift = shift_of(d, q_sel);

        wide = 24'(bus.coeff_in);
        wide = wide <<< shift;
        if (wide > 24'sd32767)
            data_n = 16'sh7FFF;
        else if (wide < -24'sd32768)
            data_n = 16'sh8000;
        else
            data_n = wide[15:0];

        case (seg)
            2'd1:    seg_base = U_SEG_BASE;
            2'd2:    seg_base = V_SEG_BASE;
            default: seg_base = '0;
        endcase
        row_idx = {block_row, 3'b000} + {5'd0, r};
        row_off = (seg == 2'd0) ? 18'(row_idx) * 18'd320 : 18'(row_idx) * 18'd160;
        col_off = {block_col, 3'b000} + {6'd0, c};
        addr_n  = PRE_IDCT_BASE + seg_base + row_off + {9'd0, col_off};
    end

    always_comb begin
        state_n = state;
        case (state)
            S_DQ_IDLE:   if (bus.Enable) state_n = S_DQ_ACTIVE;
            S_DQ_ACTIVE: if (last_coeff) state_n = S_DQ_FLUSH;
            S_DQ_FLUSH:  state_n = S_DQ_DONE;
            S_DQ_DONE:   state_n = S_DQ_IDLE;
            default:     state_n = S_DQ_IDLE;
        endcase
        bus.coeff_ready = (state == S_DQ_ACTIVE);
        bus.Done        = (state == S_DQ_DONE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state               <= S_DQ_IDLE;
            k                   <= '0;
            block_col           <= '0;
            block_row           <= '0;
            seg                 <= '0;
            q_sel               <= 1'b0;
            bus.SRAM_we_n       <= 1'b1;
            bus.SRAM_address    <= '0;
            bus.SRAM_write_data <= '0;
        end else begin
            state         <= state_n;
            bus.SRAM_we_n <= !accept;
            if (state == S_DQ_IDLE && bus.Enable) begin
                k         <= '0;
                block_col <= '0;
                block_row <= '0;
                seg       <= '0;
                q_sel     <= bus.Q_select;
            end
            if (accept) begin
                bus.SRAM_address    <= addr_n;
                bus.SRAM_write_data <= data_n;
                // Nested wrap: k -> block_col -> block_row -> seg.
                k <= k + 6'd1;
                if (k == 6'd63) begin
                    block_col <= block_col + 6'd1;
                    if (last_col) begin
                        block_col <= '0;
                        block_row <= block_row + 5'd1;
                        if (last_row) begin
                            block_row <= '0;
                            seg       <= (seg == 2'd2) ? 2'd0 : seg + 2'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dequant_zigzag_writer.sv
// Directed bench for dequant_zigzag_writer: a full-size instance for address and
// data vectors plus a reduced-row instance for a complete frame with random gaps.
module tb_dequant_zigzag_writer;

    localparam int N_SMALL = 160 * 64;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    dequant_zigzag_writer_if a0();
    dequant_zigzag_writer_if a1();

    dequant_zigzag_writer u0 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (a0)
    );

    dequant_zigzag_writer #(
        .Y_BLOCK_ROWS  (2),
        .UV_BLOCK_ROWS (2)
    ) u1 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (a1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Natural (row*8+col) index of each zig-zag position.
    int zz [64] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
    int sh0 [15] = '{3, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 7, 7, 7};
    int sh1 [15] = '{3, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 5, 5, 5};

    int exp_addr [N_SMALL];
    int exp_data [N_SMALL];
    bit seen [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%h), expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Address model for the reduced instance: Y 40x2 blocks, U and V 20x2 blocks.
    function automatic int model_addr(input int idx);
        int blk, kk, r, c, base, stride, b, cols;
        blk = idx / 64;
        kk  = idx % 64;
        r   = zz[kk] / 8;
        c   = zz[kk] % 8;
        if (blk < 80) begin
            base = 0;      stride = 320; b = blk;       cols = 40;
        end else if (blk < 120) begin
            base = 76800;  stride = 160; b = blk - 80;  cols = 20;
        end else begin
            base = 115200; stride = 160; b = blk - 120; cols = 20;
        end
        return 76800 + base + (8 * (b / cols) + r) * stride + 8 * (b % cols) + c;
    endfunction

    function automatic int model_data(input int idx, input int coeff, input bit q);
        int kk, dd, s, v;
        kk = idx % 64;
        dd = zz[kk] / 8 + zz[kk] % 8;
        s  = q ? sh1[dd] : sh0[dd];
        v  = coeff * (1 << s);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    task automatic push0(input logic [15:0] v);
        a0.coeff_in    = v;
        a0.coeff_valid = 1'b1;
        @(negedge Clock);
        a0.coeff_valid = 1'b0;
    endtask

    task automatic skip0(input int n);
        repeat (n) push0(16'd0);
    endtask

    initial begin
        int sent, got, cyc, cf;

        Reset = 1'b1;
        a0.Enable = 1'b0; a0.Q_select = 1'b0; a0.coeff_in = '0; a0.coeff_valid = 1'b0;
        a1.Enable = 1'b0; a1.Q_select = 1'b0; a1.coeff_in = '0; a1.coeff_valid = 1'b0;
        repeat (2) @(negedge Clock);
        chk("reset_we_n",  32'(a0.SRAM_we_n), 1);
        chk("reset_addr",  32'(a0.SRAM_address), 0);
        chk("reset_data",  sx(a0.SRAM_write_data), 0);
        chk("reset_ready", 32'(a0.coeff_ready), 0);
        chk("reset_done",  32'(a0.Done), 0);
        Reset = 1'b0;
        @(negedge Clock);

        // Start with Q0; the later change to Q1 must not take effect.
        a0.Enable = 1'b1; a0.Q_select = 1'b0;
        @(negedge Clock);
        a0.Enable = 1'b0; a0.Q_select = 1'b1;
        chk("start_ready", 32'(a0.coeff_ready), 1);
        chk("start_we_n",  32'(a0.SRAM_we_n), 1);

        push0(16'sd3);
        chk("k0_we_n", 32'(a0.SRAM_we_n), 0);
        chk("k0_addr", 32'(a0.SRAM_address), 76800);
        chk("k0_data", sx(a0.SRAM_write_data), 24);
        push0(16'd0);
        push0(-16'sd5);
        chk("k2_addr", 32'(a0.SRAM_address), 77120);
        chk("k2_data", sx(a0.SRAM_write_data), -20);

        // Stall with a stray Enable: outputs hold, write strobe idle.
        a0.Enable = 1'b1;
        repeat (3) @(negedge Clock);
        a0.Enable = 1'b0;
        chk("stall_we_n",  32'(a0.SRAM_we_n), 1);
        chk("stall_addr",  32'(a0.SRAM_address), 77120);
        chk("stall_data",  sx(a0.SRAM_write_data), -20);
        chk("stall_ready", 32'(a0.coeff_ready), 1);

        push0(16'sd1);
        chk("k3_addr", 32'(a0.SRAM_address), 77440);
        chk("k3_data", sx(a0.SRAM_write_data), 8);
        skip0(59);
        push0(16'sd300);
        chk("k63_sat_addr", 32'(a0.SRAM_address), 79047);
        chk("k63_sat_pos",  sx(a0.SRAM_write_data), 32767);

        push0(16'sd1);
        chk("blk1_addr", 32'(a0.SRAM_address), 76808);
        chk("blk1_data", sx(a0.SRAM_write_data), 8);
        skip0(62);
        push0(-16'sd300);
        chk("blk1_k63_addr", 32'(a0.SRAM_address), 79055);
        chk("k63_sat_neg",   sx(a0.SRAM_write_data), -32768);

        skip0(37 * 64 + 63);
        push0(16'd0);
        chk("blk39_k63_addr", 32'(a0.SRAM_address), 79359);
        push0(16'sd2);
        chk("blk40_addr", 32'(a0.SRAM_address), 79360);
        chk("blk40_data", sx(a0.SRAM_write_data), 16);
        chk("mid_done",   32'(a0.Done), 0);

        skip0(5000 - 2561);
        chk("w5000_we_n", 32'(a0.SRAM_we_n), 0);
        chk("w5000_addr", 32'(a0.SRAM_address), 79986);

        // Reset mid-frame with Enable and valid asserted alongside it.
        Reset = 1'b1; a0.Enable = 1'b1; a0.coeff_valid = 1'b1;
        @(negedge Clock);
        Reset = 1'b0; a0.Enable = 1'b0; a0.coeff_valid = 1'b0;
        chk("rst_we_n",  32'(a0.SRAM_we_n), 1);
        chk("rst_addr",  32'(a0.SRAM_address), 0);
        chk("rst_data",  sx(a0.SRAM_write_data), 0);
        chk("rst_ready", 32'(a0.coeff_ready), 0);
        chk("rst_done",  32'(a0.Done), 0);
        @(negedge Clock);
        chk("rst_prio_ready", 32'(a0.coeff_ready), 0);

        a0.Enable = 1'b1; a0.Q_select = 1'b1;
        @(negedge Clock);
        a0.Enable = 1'b0;
        chk("restart_ready", 32'(a0.coeff_ready), 1);
        push0(16'sd7);
        chk("restart_addr", 32'(a0.SRAM_address), 76800);
        chk("q1_k0_data",   sx(a0.SRAM_write_data), 56);
        push0(16'sd7);
        chk("q1_k1_addr", 32'(a0.SRAM_address), 76801);
        chk("q1_k1_data", sx(a0.SRAM_write_data), 14);
        chk("restart_done", 32'(a0.Done), 0);

        // Complete reduced frame on u1 with Q1 latched and random valid gaps.
        a1.Enable = 1'b1; a1.Q_select = 1'b1;
        @(negedge Clock);
        a1.Enable = 1'b0; a1.Q_select = 1'b0;
        sent = 0; got = 0; cyc = 0;
        while (got < N_SMALL && cyc < 60000) begin
            if (sent < N_SMALL && $urandom_range(0, 3) != 0) begin
                cf = int'($urandom_range(0, 4095)) - 2048;
                a1.coeff_in    = 16'(cf);
                a1.coeff_valid = 1'b1;
                exp_addr[sent] = model_addr(sent);
                exp_data[sent] = model_data(sent, cf, 1'b1);
                sent++;
            end else begin
                a1.coeff_valid = 1'b0;
            end
            @(negedge Clock);
            cyc++;
            if (a1.SRAM_we_n === 1'b0) begin
                chk("frame_addr", 32'(a1.SRAM_address), exp_addr[got]);
                chk("frame_data", sx(a1.SRAM_write_data), exp_data[got]);
                chk("frame_dup",  32'(seen.exists(int'(a1.SRAM_address))), 0);
                seen[int'(a1.SRAM_address)] = 1'b1;
                if (got == 5120)        chk("u_start_addr", 32'(a1.SRAM_address), 153600);
                if (got == 5122)        chk("u_k2_addr",    32'(a1.SRAM_address), 153760);
                if (got == 7680)        chk("v_start_addr", 32'(a1.SRAM_address), 192000);
                if (got == N_SMALL - 1) chk("last_addr",    32'(a1.SRAM_address), 194559);
                got++;
            end
        end
        a1.coeff_valid = 1'b0;
        chk("frame_writes", 32'(got), N_SMALL);
        chk("flush_ready",  32'(a1.coeff_ready), 0);
        chk("flush_done",   32'(a1.Done), 0);
        @(negedge Clock);
        chk("done_pulse", 32'(a1.Done), 1);
        chk("done_we_n",  32'(a1.SRAM_we_n), 1);
        chk("done_ready", 32'(a1.coeff_ready), 0);
        @(negedge Clock);
        chk("done_clear", 32'(a1.Done), 0);
        chk("idle_we_n",  32'(a1.SRAM_we_n), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dequant_zigzag_writer.md
# dequant_zigzag_writer

Upstream neighbour of the IDCT stage. Accepts a stream of quantized DCT coefficients in zig-zag order, dequantizes each one with the selected quantization matrix, and writes it row-major into the pre-IDCT region of SRAM. The IDCT stage reads that region from address 76800 up to 230399. One coefficient is written per cycle at full throughput.

## Interface
- PRE_IDCT_BASE, 18'd76800, first SRAM address of the pre-IDCT region
- Y_BLOCK_COLS, 40 / Y_BLOCK_ROWS, 30, Y segment size in 8x8 blocks, row stride 320
- UV_BLOCK_COLS, 20 / UV_BLOCK_ROWS, 30, U and V segment size in blocks, row stride 160
- Clock  in  1  system clock, all logic on its rising edge
- Reset  in  1  synchronous, active-high reset
- Enable  in  1  start pulse, sampled only in S_DQ_IDLE
- Q_select  in  1  quantization matrix, 0 = Q0, 1 = Q1; latched at start
- coeff_in  in  16  signed quantized coefficient
- coeff_valid  in  1  coeff_in is valid
- coeff_ready  out  1  block accepts a coefficient
- SRAM_address  out  18  write address
- SRAM_write_data  out  16  signed dequantized coefficient
- SRAM_we_n  out  1  active-low write enable
- Done  out  1  one-cycle pulse when the frame is complete

## Operation
- States:
  - S_DQ_IDLE, on Enable -> S_DQ_ACTIVE
  - S_DQ_ACTIVE, after the 153600th acceptance -> S_DQ_FLUSH
  - S_DQ_FLUSH -> S_DQ_DONE
  - S_DQ_DONE -> S_DQ_IDLE, with Done = 1 for that one cycle
- Counters are cleared on Enable: k (0..63), block_col, block_row, seg (0 = Y, 1 = U, 2 = V). Q_select is latched at the same time.
- Acceptance happens when coeff_valid && coeff_ready. coeff_ready = 1 only in S_DQ_ACTIVE. It is decoded from state, not registered.
- Zig-zag mapping k -> (r, c) follows anti-diagonals d = r + c:
  - odd d: traverse with r increasing
  - even d: traverse with r decreasing
  - Examples: k0 = (0,0), k1 = (0,1), k2 = (1,0), k3 = (2,0), k5 = (0,2), k9 = (3,0), k10 = (4,0), k63 = (7,7).
- Shift is selected by d:
  - Q0: d0 = 3, d1 = 2, d2-3 = 3, d4-5 = 4, d6-7 = 5, d8-9 = 6, d10-14 = 7
  - Q1: d0 = 3, d1-3 = 1, d4-5 = 2, d6-7 = 3, d8-9 = 4, d10-14 = 5
- Dequantization: data = coeff_in <<< shift, computed at 24 bits. The result saturates to [-32768, 32767].
- Address: PRE_IDCT_BASE + seg_base + (8·block_row + r)·stride + 8·block_col + c
  - seg_base: Y = 0, U = 76800, V = 115200
  - stride: Y = 320, U/V = 160
- Counter advance on acceptance:
  - k wraps 63 -> 0 and then increments block_col.
  - block_col wraps at the segment's column count and then increments block_row.
  - block_row wraps at 30 and then increments seg.
- Blocks are written row-major within a segment, and segments in the order Y, U, V. That is 2400 blocks, 153600 writes in total.

## Timing
- Reset values: SRAM_we_n = 1, SRAM_address = 0, SRAM_write_data = 0, coeff_ready = 0, Done = 0, state = S_DQ_IDLE, all counters 0.
- Latency: an acceptance in cycle t drives registered SRAM_address, SRAM_write_data and SRAM_we_n = 0 in cycle t+1.
- A cycle without acceptance drives SRAM_we_n = 1 in the next cycle. Address and data hold their previous values; counters hold.
- coeff_valid may drop mid-block; a stall of any length resumes at the same k.
- The final write (address 230399) is presented in S_DQ_FLUSH with coeff_ready = 0. Done pulses in the following cycle, and SRAM_we_n = 1 again from that cycle.
- Enable outside S_DQ_IDLE is ignored. Q_select changes after the start are ignored.
- Reset asserted mid-frame takes effect at the next edge:
  - all outputs return to their reset values
  - any partially written frame is abandoned and is not resumed
- Reset has priority over Enable in the same cycle.

## Test plan
- Reset, then Enable with Q0. Send coeff 3 at k0 and -5 at k2. Required: write (76800, 24) in cycle t+1 and write (77120, -20).
- Block wrap: k0 of Y block 1 -> address 76808. k0 of block 40 -> 79360. k63 of block 39 -> 76800 + 7·320 + 319 = 79359.
- Segment transition: k0 of block 1200 -> 153600, with 160 stride (k2 -> 153760). k0 of block 1800 -> 192000. k63 of block 2399 -> 230399. Then coeff_ready = 0 and Done = 1 exactly one cycle after that write.
- Saturation and Q1: with Q0, k63 coeff 300 -> 32767 and coeff -300 -> -32768. With Q1, k1 coeff 7 -> 14.
- Random coeff_valid gaps over a full frame: exactly 153600 we_n = 0 cycles, no duplicate addresses, each data word equal to the reference model.
- Reset pulse at write 5000, then Enable again: outputs return to reset values, and the first new write goes to 76800 with Done not asserted.
